// File: rtl/irrigation_pkg.sv
// irrigation_pkg: shared FSM states, method encoding and round-robin zone search
package irrigation_pkg;
  typedef enum logic [2:0] {IDLE, SELECT, WATER, REST, FAULT} state_t;
  localparam logic METHOD_SPRINKLER = 1'b0;
  localparam logic METHOD_DRIP = 1'b1;
  localparam int MAX_ZONES = 16;
  function automatic logic [4:0] next_dry_zone(input logic [MAX_ZONES-1:0] dry, input logic [3:0] ptr, input int n);
    logic [4:0] r;
    r = '0;
    for (int i = MAX_ZONES; i >= 1; i--)
      if (i <= n && dry[4'((int'(ptr) + i) % n)]) r = {1'b1, 4'((int'(ptr) + i) % n)};
    return r;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running divider giving a one-cycle tick every TICK_DIV clocks
module tick_prescaler #(
  parameter int TICK_DIV = 50000000,
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  logic [CW-1:0] cnt;
  // Count 0..TICK_DIV-1 and pulse tick on wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      tick <= 1'b0;
    end else begin
      cnt <= cnt == CW'(TICK_DIV - 1) ? '0 : cnt + CW'(1);
      tick <= cnt == CW'(TICK_DIV - 1);
    end
  end
endmodule

// File: rtl/irrigation_zone_scheduler.sv
// irrigation_zone_scheduler: round-robin multi-zone watering from one tank; define RUN_COUNT_EN for run_count_o
module irrigation_zone_scheduler
  import irrigation_pkg::*;
#(
  parameter int N_ZONES = 4,
  parameter int TICK_DIV = 50000000,
  parameter int DUR_W = 12,
  parameter int SPRINKLE_T = 420,
  parameter int DRIP_T = 900,
  parameter int REST_T = 60,
  localparam int ZW = $clog2(N_ZONES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               high_level_indicator_i,
  input  logic               middle_level_indicator_i,
  input  logic               low_level_indicator_i,
  input  logic [N_ZONES-1:0] soil_dry_i,
  input  logic               air_humidity_i,
  input  logic               temperature_i,
  input  logic               enable_i,
  output logic [N_ZONES-1:0] zone_valve_o,
  output logic               sprinkler_o,
  output logic               drip_o,
  output logic [ZW-1:0]      active_zone_o,
  output logic [DUR_W-1:0]   remaining_o,
  output logic               inlet_valve_o,
  output logic               alarm_state_o,
  output logic               error_indicator_o,
`ifdef RUN_COUNT_EN
  output logic [15:0]        run_count_o,
`endif
  output logic               busy_o
);
  state_t state, next_state;
  logic tick, method, done, drip_now, run_end, on, sensor_err, pick_ok;
  logic [3:0] pick_idx;
  logic [DUR_W-1:0] cnt, cnt_d, rem_d;
  logic [ZW-1:0] ptr, active;
  logic [N_ZONES-1:0] valve_d;
  logic spr_d, drip_d;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .reset(reset), .tick(tick));

  assign {pick_ok, pick_idx} = next_dry_zone(MAX_ZONES'(soil_dry_i), 4'(ptr), N_ZONES);
  assign sensor_err = (high_level_indicator_i & ~middle_level_indicator_i) | (middle_level_indicator_i & ~low_level_indicator_i);
  assign drip_now = temperature_i | ~air_humidity_i | ~middle_level_indicator_i;
  assign done = (tick && cnt <= DUR_W'(1)) || cnt == '0;
  assign run_end = state == WATER && next_state == REST;

  // Tank sensor decode, one cycle of latency
  always_ff @(posedge clk) begin
    if (reset) begin
      error_indicator_o <= 1'b0;
      alarm_state_o <= 1'b0;
      inlet_valve_o <= 1'b0;
    end else begin
      error_indicator_o <= sensor_err;
      alarm_state_o <= sensor_err | ~low_level_indicator_i;
      inlet_valve_o <= ~high_level_indicator_i & ~sensor_err;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= next_state;
  end

  // Next state; alarm or disable beats timer expiry during a run
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = enable_i && !alarm_state_o && |soil_dry_i ? SELECT : IDLE;
      SELECT:  next_state = pick_ok ? WATER : IDLE;
      WATER:   next_state = alarm_state_o || !enable_i ? FAULT : done || !soil_dry_i[active] ? REST : WATER;
      REST:    next_state = done ? SELECT : REST;
      FAULT:   next_state = !alarm_state_o && enable_i ? IDLE : FAULT;
      default: next_state = IDLE;
    endcase
  end

  // Duration counter: load on run start and rest start, count down on tick
  always_comb begin
    cnt_d = cnt;
    if (state == SELECT) cnt_d = drip_now ? DUR_W'(DRIP_T) : DUR_W'(SPRINKLE_T);
    else if (run_end) cnt_d = DUR_W'(REST_T);
    else if ((state == WATER || state == REST) && tick && cnt != '0) cnt_d = cnt - DUR_W'(1);
  end

  // Counter, chosen zone, latched method and last credited zone
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      ptr <= ZW'(N_ZONES - 1);
      active <= '0;
      method <= METHOD_SPRINKLER;
    end else begin
      cnt <= cnt_d;
      if (state == SELECT && pick_ok) begin
        active <= ZW'(pick_idx);
        method <= drip_now ? METHOD_DRIP : METHOD_SPRINKLER;
      end
      if (run_end) ptr <= active;
    end
  end

  // Output decode: valves only while a run continues, so they drop as the run leaves WATER
  always_comb begin
    on = state == WATER && next_state == WATER;
    valve_d = on ? N_ZONES'(1) << active : '0;
    spr_d = on && method == METHOD_SPRINKLER;
    drip_d = on && method == METHOD_DRIP;
    rem_d = next_state == WATER || next_state == REST ? cnt_d : '0;
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      zone_valve_o <= '0;
      sprinkler_o <= 1'b0;
      drip_o <= 1'b0;
      active_zone_o <= '0;
      remaining_o <= '0;
      busy_o <= 1'b0;
    end else begin
      zone_valve_o <= valve_d;
      sprinkler_o <= spr_d;
      drip_o <= drip_d;
      active_zone_o <= active;
      remaining_o <= rem_d;
      busy_o <= next_state != IDLE;
    end
  end

`ifdef RUN_COUNT_EN
  // Count runs ending by timer or wet soil, saturating
  always_ff @(posedge clk) begin
    if (reset) run_count_o <= '0;
    else if (run_end && run_count_o != 16'hFFFF) run_count_o <= run_count_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// tb_irrigation_zone_scheduler: scoreboard bench for the zone scheduler with small timing parameters
module tb_irrigation_zone_scheduler;
  localparam int TD = 4, ST = 3, DT = 5, RT = 2;
  typedef struct packed {logic [3:0] v; logic s; logic d;} ev_t;

  logic clk = 0, reset, high, mid, low, air, temp, en;
  logic [3:0] soil, zone_valve_o;
  logic sprinkler_o, drip_o, inlet_valve_o, alarm_state_o, error_indicator_o, busy_o;
  logic [1:0] active_zone_o;
  logic [11:0] remaining_o;
`ifdef RUN_COUNT_EN
  logic [15:0] run_count_o;
`endif
  int errors = 0, checks = 0, n;
  bit mon_en = 0;
  ev_t sb[$];

  irrigation_zone_scheduler #(.N_ZONES(4), .TICK_DIV(TD), .DUR_W(12), .SPRINKLE_T(ST), .DRIP_T(DT), .REST_T(RT)) dut (
    .clk(clk), .reset(reset),
    .high_level_indicator_i(high), .middle_level_indicator_i(mid), .low_level_indicator_i(low),
    .soil_dry_i(soil), .air_humidity_i(air), .temperature_i(temp), .enable_i(en),
    .zone_valve_o(zone_valve_o), .sprinkler_o(sprinkler_o), .drip_o(drip_o),
    .active_zone_o(active_zone_o), .remaining_o(remaining_o),
    .inlet_valve_o(inlet_valve_o), .alarm_state_o(alarm_state_o), .error_indicator_o(error_indicator_o),
`ifdef RUN_COUNT_EN
    .run_count_o(run_count_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_valve(input string name, input logic [3:0] v, input int budget);
    int k = 0;
    while (zone_valve_o !== v && k < budget) begin @(negedge clk); k++; end
    chk(name, zone_valve_o, v);
  endtask

  task automatic run_len(input logic [3:0] v, input int budget, output int k);
    k = 0;
    while (zone_valve_o === v && k < budget) begin @(negedge clk); k++; end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy_o !== 1'b0 && k < budget) begin @(negedge clk); k++; end
    chk(name, busy_o, 0);
  endtask

  function automatic logic [31:0] all_out();
    return {8'd0, zone_valve_o, sprinkler_o, drip_o, active_zone_o, remaining_o,
            inlet_valve_o, alarm_state_o, error_indicator_o, busy_o};
  endfunction

  // Monitor: pop an expected valve/method event on every output change, check one-hot each cycle
  initial begin
    ev_t prev, cur, exp;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {zone_valve_o, sprinkler_o, drip_o};
      if (mon_en) begin
        chk("valve_onehot0", 32'($onehot0(zone_valve_o)), 1);
        if (cur != prev) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %b/%b/%b expected no change", cur.v, cur.s, cur.d);
          end else begin
            exp = sb.pop_front();
            chk("valve_event", 32'(cur), 32'(exp));
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000ns");
    $fatal(1);
  end

  initial begin
    int busy_seen;
    reset = 1; high = 1; mid = 1; low = 1; soil = 0; air = 1; temp = 0; en = 1;
    // Reset: everything 0 while asserted, sensors decoded after release
    repeat (2) begin @(negedge clk); chk("reset_outputs", all_out(), 0); end
    reset = 0;
    @(negedge clk);
    chk("inlet_after_reset", inlet_valve_o, 0);
    chk("alarm_after_reset", alarm_state_o, 0);
    chk("busy_after_reset", busy_o, 0);
    mon_en = 1;
    // Round-robin: zone 0 then zone 2, sprinkler
    sb.push_back('{4'b0001, 1, 0}); sb.push_back('{4'b0000, 0, 0});
    sb.push_back('{4'b0100, 1, 0}); sb.push_back('{4'b0000, 0, 0});
    soil = 4'b0101;
    wait_valve("rr_zone0_on", 4'b0001, 20);
    chk("rr_zone0_index", active_zone_o, 0);
    run_len(4'b0001, 40, n);
    chk_range("rr_zone0_len", n, (ST - 1) * TD, ST * TD - 1);
    run_len(4'b0000, 40, n);
    chk_range("rr_rest_gap", n, (RT - 1) * TD + 2, RT * TD + 2);
    chk("rr_zone2_on", zone_valve_o, 4'b0100);
    chk("rr_zone2_index", active_zone_o, 2);
    soil = 0;
    wait_idle("rr_idle", 40);
    // Drip selection on hot weather, zone 3
    sb.push_back('{4'b1000, 0, 1}); sb.push_back('{4'b0000, 0, 0});
    temp = 1; soil = 4'b1000;
    wait_valve("drip_zone3_on", 4'b1000, 20);
    chk("drip_zone3_index", active_zone_o, 3);
    run_len(4'b1000, 60, n);
    chk_range("drip_len", n, (DT - 1) * TD, DT * TD - 1);
    soil = 0; temp = 0;
    wait_idle("drip_idle", 40);
    // Fault mid-run, then the same zone is served again
    sb.push_back('{4'b0001, 1, 0}); sb.push_back('{4'b0000, 0, 0});
    sb.push_back('{4'b0001, 1, 0}); sb.push_back('{4'b0000, 0, 0});
    soil = 4'b0001;
    wait_valve("fault_zone0_on", 4'b0001, 20);
    mid = 0;
    @(negedge clk);
    chk("fault_error", error_indicator_o, 1);
    chk("fault_alarm", alarm_state_o, 1);
    @(negedge clk);
    chk("fault_valves_off", zone_valve_o, 0);
    chk("fault_busy", busy_o, 1);
    chk("fault_remaining", remaining_o, 0);
    mid = 1;
    wait_valve("fault_reserve_zone0", 4'b0001, 40);
    // Early stop: soil turns wet after the first tick
    n = 0;
    while (remaining_o !== 12'(ST - 1) && n < 20) begin @(negedge clk); n++; end
    chk("early_after_tick", remaining_o, ST - 1);
    soil = 0;
    @(negedge clk);
    chk("early_valves_off", zone_valve_o, 0);
    chk("early_rest_load", remaining_o, RT);
    wait_idle("early_idle", 40);
`ifdef RUN_COUNT_EN
    chk("run_count", run_count_o, 4);
`endif
    // Empty tank: alarm and fill, no run starts
    high = 0; mid = 0; low = 0;
    repeat (2) @(negedge clk);
    soil = 4'b1111;
    busy_seen = 0;
    repeat (12) begin @(negedge clk); busy_seen |= int'(busy_o); end
    chk("empty_stays_idle", busy_seen, 0);
    chk("empty_alarm", alarm_state_o, 1);
    chk("empty_inlet", inlet_valve_o, 1);
    chk("empty_error", error_indicator_o, 0);
    soil = 0; high = 1; mid = 1; low = 1;
    repeat (2) @(negedge clk);
    // Reset during a run drops valves at the next edge
    sb.push_back('{4'b0010, 1, 0}); sb.push_back('{4'b0000, 0, 0});
    soil = 4'b0010;
    wait_valve("reset_run_zone1_on", 4'b0010, 20);
    reset = 1;
    @(negedge clk);
    chk("reset_mid_run", all_out(), 0);
    reset = 0; soil = 0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
